rf_text_scroll_engine: RTL and testbench

Autonomous block-move/fill engine for the text screen RAM. On command it fills a run of 64-bit text cells with a constant, or scrolls a run up by a cell distance and then fills the vacated tail. It sits upstream of the text screen RAM. It drives that RAM's 64-bit byte-selectable port through a request/grant arbiter shared with the CPU.

---
 rtl/rf_text_scroll_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_rf_text_scroll_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_text_scroll_engine.sv
// Fill / scroll-up block-move engine for the text screen RAM, arbitrated via cs/gnt.
// Optional `TEXT_SCROLL_BYTEMASK_EN adds fill_mask_i to byte-mask FILL writes.

module rf_text_scroll_engine #(
    parameter int unsigned TEXT_CELL_COUNT = 16384,
    parameter int unsigned RD_LAT          = 2,
    localparam int unsigned AWID           = $clog2(TEXT_CELL_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            cmd_i,
    input  logic [AWID-1:0] base_i,
    input  logic [AWID:0]   count_i,
    input  logic [AWID-1:0] dist_i,
    input  logic [63:0]     fill_i,
`ifdef TEXT_SCROLL_BYTEMASK_EN
    input  logic [7:0]      fill_mask_i,
`endif
    output logic            busy_o,
    output logic            done_o,
    output logic            ram_cs_o,
    input  logic            ram_gnt_i,
    output logic            ram_we_o,
    output logic [7:0]      ram_sel_o,
    output logic [AWID-1:0] ram_adr_o,
    output logic [63:0]     ram_dat_o,
    input  logic [63:0]     ram_dat_i
);

    localparam int unsigned CW = AWID + 1;
    localparam int unsigned WW = 2;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [AWID-1:0] OFF_ONE  = AWID'(1);
    localparam logic [WW-1:0]   WAIT_ONE = WW'(1);
    localparam logic [WW-1:0]   WAIT_INI = WW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_MOVE_RD, S_MOVE_WAIT, S_MOVE_WR, S_FILL, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            cmd_q, cmd_d;
    logic [AWID-1:0] base_q, base_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AWID-1:0] dist_q, dist_d;
    logic [63:0]     fill_q, fill_d;
    logic [CW-1:0]   mv_left_q, mv_left_d;
    logic [CW-1:0]   fl_left_q, fl_left_d;
    logic [AWID-1:0] off_q, off_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [63:0]     word_q, word_d;
    logic [7:0]      mask_q, mask_d;

    logic            cs_q, cs_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]      sel_q, sel_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [63:0]     dat_q, dat_d;

    // Next state, then output registers decoded from the state being entered.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        base_d    = base_q;
        count_d   = count_q;
        dist_d    = dist_q;
        fill_d    = fill_q;
        mv_left_d = mv_left_q;
        fl_left_d = fl_left_q;
        off_d     = off_q;
        wait_d    = wait_q;
        word_d    = word_q;
        mask_d    = mask_q;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        sel_d     = 8'h00;
        adr_d     = '0;
        dat_d     = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cmd_d   = cmd_i;
                    base_d  = base_i;
                    count_d = count_i;
                    dist_d  = dist_i;
                    fill_d  = fill_i;
`ifdef TEXT_SCROLL_BYTEMASK_EN
                    mask_d  = fill_mask_i;
`else
                    mask_d  = 8'hFF;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                off_d = '0;
                if (count_q == '0) begin
                    state_d = S_DONE;
                end else if (!cmd_q || ({1'b0, dist_q} >= count_q)) begin
                    mv_left_d = '0;
                    fl_left_d = count_q;
                    state_d   = S_FILL;
                end else begin
                    mv_left_d = count_q - {1'b0, dist_q};
                    fl_left_d = {1'b0, dist_q};
                    state_d   = S_MOVE_RD;
                end
            end
            S_MOVE_RD: begin
                if (ram_gnt_i) begin
                    wait_d  = WAIT_INI;
                    state_d = S_MOVE_WAIT;
                end
            end
            S_MOVE_WAIT: begin
                // Grant is deliberately ignored: the port stays ours until the word returns.
                if (wait_q == '0) begin
                    word_d  = ram_dat_i;
                    state_d = S_MOVE_WR;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            S_MOVE_WR: begin
                if (ram_gnt_i) begin
                    off_d     = off_q + OFF_ONE;
                    mv_left_d = mv_left_q - CNT_ONE;
                    if (mv_left_q != CNT_ONE) begin
                        state_d = S_MOVE_RD;
                    end else if (fl_left_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (ram_gnt_i) begin
                    off_d     = off_q + OFF_ONE;
                    fl_left_d = fl_left_q - CNT_ONE;
                    if (fl_left_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_SETUP: begin
                busy_d = 1'b1;
            end
            S_MOVE_RD, S_MOVE_WAIT: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                adr_d  = base_d + dist_d + off_d;
            end
            S_MOVE_WR: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                we_d   = 1'b1;
                sel_d  = 8'hFF;
                adr_d  = base_d + off_d;
                dat_d  = word_d;
            end
            S_FILL: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                we_d   = 1'b1;
                sel_d  = mask_d;
                adr_d  = base_d + off_d;
                dat_d  = fill_d;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cmd_q     <= 1'b0;
            base_q    <= '0;
            count_q   <= '0;
            dist_q    <= '0;
            fill_q    <= '0;
            mv_left_q <= '0;
            fl_left_q <= '0;
            off_q     <= '0;
            wait_q    <= '0;
            word_q    <= '0;
            mask_q    <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 8'h00;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            base_q    <= base_d;
            count_q   <= count_d;
            dist_q    <= dist_d;
            fill_q    <= fill_d;
            mv_left_q <= mv_left_d;
            fl_left_q <= fl_left_d;
            off_q     <= off_d;
            wait_q    <= wait_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ram_cs_o  = cs_q;
    assign ram_we_o  = we_q;
    assign ram_sel_o = sel_q;
    assign ram_adr_o = adr_q;
    assign ram_dat_o = dat_q;

endmodule

// File: tb/tb_rf_text_scroll_engine.sv
// Self-checking bench for rf_text_scroll_engine: RAM model, monitor and array reference model.

module tb_rf_text_scroll_engine;

    localparam int N   = 16384;
    localparam int AW  = 14;
    localparam int RDL = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          cmd_i = 1'b0;
    logic [AW-1:0] base_i = '0;
    logic [AW:0]   count_i = '0;
    logic [AW-1:0] dist_i = '0;
    logic [63:0]   fill_i = '0;
    logic          busy_o, done_o, ram_cs_o, ram_we_o;
    logic          ram_gnt_i = 1'b1;
    logic [7:0]    ram_sel_o;
    logic [AW-1:0] ram_adr_o;
    logic [63:0]   ram_dat_o;
    logic [63:0]   ram_dat_i = '0;

    rf_text_scroll_engine #(.TEXT_CELL_COUNT(N), .RD_LAT(RDL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .cmd_i(cmd_i),
        .base_i(base_i), .count_i(count_i), .dist_i(dist_i), .fill_i(fill_i),
`ifdef TEXT_SCROLL_BYTEMASK_EN
        .fill_mask_i(8'hFF),
`endif
        .busy_o(busy_o), .done_o(done_o), .ram_cs_o(ram_cs_o), .ram_gnt_i(ram_gnt_i),
        .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_adr_o(ram_adr_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    always #5 clk_i = ~clk_i;

    logic [63:0] mem     [N];
    logic [63:0] ref_mem [N];
    int          hits    [N];
    logic [63:0] rd_dly = '0;
    bit          load_req = 1'b0;
    int edge_cnt = 0, start_edge = 32'h7fff_ffff;
    int wr_cnt = 0, rd_cnt = 0, cs_cnt = 0, busy_cnt = 0, done_cnt = 0, done_rel = -1;
    int wr_adr [64];
    int wr_rel [64];
    int checks = 0, errors = 0;

    // RAM with RD_LAT=2 read pipeline plus transaction monitor.
    always @(posedge clk_i) begin
        edge_cnt = edge_cnt + 1;
        if (load_req) for (int k = 0; k < N; k++) mem[k] = ref_mem[k];
        if (edge_cnt == start_edge) begin
            wr_cnt = 0; rd_cnt = 0; cs_cnt = 0; busy_cnt = 0; done_cnt = 0; done_rel = -1;
            for (int k = 0; k < N; k++) hits[k] = 0;
        end
        rd_dly    <= mem[ram_adr_o];
        ram_dat_i <= rd_dly;
        if (ram_cs_o) cs_cnt = cs_cnt + 1;
        if (ram_cs_o && !ram_we_o && ram_gnt_i) rd_cnt = rd_cnt + 1;
        if (ram_cs_o && ram_we_o && ram_gnt_i) begin
            for (int b = 0; b < 8; b++)
                if (ram_sel_o[b]) mem[ram_adr_o][8*b +: 8] = ram_dat_o[8*b +: 8];
            hits[ram_adr_o] = hits[ram_adr_o] + 1;
            if (wr_cnt < 64) begin
                wr_adr[wr_cnt] = int'(ram_adr_o);
                wr_rel[wr_cnt] = edge_cnt - start_edge;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (busy_o) busy_cnt = busy_cnt + 1;
        if (done_o) begin
            done_cnt = done_cnt + 1;
            if (done_rel < 0) done_rel = edge_cnt - start_edge;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the command rules, on a plain array.
    function automatic void apply_ref(input bit c, input int b, input int cnt, input int d,
                                      input logic [63:0] f);
        int m, fc;
        if (c && d < cnt) begin m = cnt - d; fc = d; end
        else begin m = 0; fc = cnt; end
        for (int i = 0; i < m; i++) ref_mem[(b + i) % N] = ref_mem[(b + d + i) % N];
        for (int j = 0; j < fc; j++) ref_mem[(b + m + j) % N] = f;
    endfunction

    function automatic int exp_cycles(input bit c, input int cnt, input int d);
        int m, fc;
        if (c && d < cnt) begin m = cnt - d; fc = d; end
        else begin m = 0; fc = cnt; end
        return 1 + m * (RDL + 2) + fc + 1;
    endfunction

    function automatic int count_diff();
        int n = 0;
        for (int k = 0; k < N; k++) if (mem[k] !== ref_mem[k]) n++;
        return n;
    endfunction

    task automatic do_load();
        @(negedge clk_i); load_req = 1'b1;
        @(negedge clk_i); load_req = 1'b0;
    endtask

    bit hold_ok;

    task automatic run_cmd(input bit c, input int b, input int cnt, input int d,
                           input logic [63:0] f, input bit rnd, input int stall_wr,
                           input int poke_cyc, input int max_cyc);
        int          stall_n = 0;
        bit          stalled = 0, released = 0;
        logic [AW-1:0] h_adr = '0;
        logic [63:0] h_dat = '0;
        apply_ref(c, b, cnt, d, f);
        hold_ok = 1'b1;
        @(negedge clk_i);
        cmd_i = c; base_i = AW'(b); count_i = (AW+1)'(cnt); dist_i = AW'(d); fill_i = f;
        start_i = 1'b1; ram_gnt_i = 1'b1;
        start_edge = edge_cnt + 1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk_i);
            start_i = (k == poke_cyc);
            if (start_i) begin
                cmd_i = ~cmd_i; base_i = base_i ^ 14'h0155; fill_i = ~fill_i;
            end
            if (done_cnt > 0) break;
            if (stall_wr >= 0 && !stalled && wr_cnt == stall_wr && ram_cs_o && ram_we_o) begin
                stalled = 1; stall_n = 3; h_adr = ram_adr_o; h_dat = ram_dat_o;
            end
            if (stall_n > 0) begin
                if (ram_adr_o !== h_adr || ram_dat_o !== h_dat) hold_ok = 1'b0;
                ram_gnt_i = 1'b0;
                stall_n--;
            end else begin
                if (stalled && !released) begin
                    if (ram_adr_o !== h_adr || ram_dat_o !== h_dat || !ram_cs_o) hold_ok = 1'b0;
                    released = 1;
                end
                ram_gnt_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        start_i = 1'b0;
        ram_gnt_i = 1'b1;
    endtask

    initial begin
        int b, cnt, d;
        bit c;
        logic [63:0] f;
        int bad;

        // Reset: all outputs low.
        repeat (3) @(negedge clk_i);
        check("reset_outs", 64'({busy_o, done_o, ram_cs_o, ram_we_o, ram_sel_o}), 64'(0));
        check("reset_adr_dat", 64'(ram_adr_o) | ram_dat_o, 64'(0));
        rst_ni = 1'b1;

        for (int k = 0; k < N; k++) ref_mem[k] = {$urandom(), $urandom()};
        do_load();
        check("preload", 64'(count_diff()), 64'(0));

        // Directed fill: base 10, count 4.
        run_cmd(1'b0, 10, 4, 0, 64'hA5, 1'b0, -1, -1, 200);
        for (int i = 0; i < 4; i++) begin
            check("fill_adr", 64'(wr_adr[i]), 64'(10 + i));
            check("fill_cyc", 64'(wr_rel[i]), 64'(2 + i));
        end
        check("fill_done_cyc", 64'(done_rel), 64'(6));
        check("fill_busy_cycles", 64'(busy_cnt), 64'(5));
        check("fill_mem", 64'(count_diff()), 64'(0));

        // Scroll up by 2 over cells 0..7 holding k.
        for (int k = 0; k < 8; k++) ref_mem[k] = 64'(k);
        do_load();
        run_cmd(1'b1, 0, 8, 2, 64'hDEAD_BEEF_0000_1111, 1'b0, -1, -1, 200);
        check("scroll_cell0", mem[0], 64'd2);
        check("scroll_cell5", mem[5], 64'd7);
        check("scroll_cell7", mem[7], 64'hDEAD_BEEF_0000_1111);
        check("scroll_done_cyc", 64'(done_rel), 64'(1 + 6 * 4 + 2 + 1));
        check("scroll_mem", 64'(count_diff()), 64'(0));

        // Wrap across the top cell.
        f = ref_mem[2];
        run_cmd(1'b0, 16382, 4, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, -1, -1, 200);
        check("wrap_cell1", mem[1], 64'h1234_5678_9ABC_DEF0);
        check("wrap_cell2_kept", mem[2], f);
        check("wrap_mem", 64'(count_diff()), 64'(0));

        // Grant stall of 3 cycles on the second fill write.
        run_cmd(1'b0, 200, 4, 0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1, -1, 200);
        check("stall_hold", 64'(hold_ok), 64'(1));
        check("stall_writes", 64'(wr_cnt), 64'(4));
        check("stall_done_cyc", 64'(done_rel), 64'(9));
        check("stall_mem", 64'(count_diff()), 64'(0));

        // count = 0.
        run_cmd(1'b1, 50, 0, 3, 64'hFFFF, 1'b0, -1, -1, 50);
        check("zero_done_cyc", 64'(done_rel), 64'(2));
        check("zero_no_cs", 64'(cs_cnt), 64'(0));
        check("zero_busy", 64'(busy_cnt), 64'(1));

        // dist >= count degenerates to a pure fill.
        run_cmd(1'b1, 400, 8, 9, 64'h5555_AAAA_5555_AAAA, 1'b0, -1, -1, 200);
        check("bigdist_no_reads", 64'(rd_cnt), 64'(0));
        check("bigdist_done_cyc", 64'(done_rel), 64'(10));
        check("bigdist_mem", 64'(count_diff()), 64'(0));

        // start_i while busy is ignored.
        run_cmd(1'b1, 300, 6, 2, 64'h7777, 1'b0, -1, 5, 200);
        repeat (6) @(negedge clk_i);
        check("poke_single_done", 64'(done_cnt), 64'(1));
        check("poke_idle_after", 64'({busy_o, ram_cs_o}), 64'(0));
        check("poke_done_cyc", 64'(done_rel), 64'(exp_cycles(1'b1, 6, 2)));
        check("poke_mem", 64'(count_diff()), 64'(0));

        // Randomized commands with random grant.
        for (int t = 0; t < 12; t++) begin
            c = 1'($urandom_range(0, 1));
            b = int'($urandom_range(0, N - 1));
            cnt = int'($urandom_range(0, 40));
            d = int'($urandom_range(0, 45));
            f = {$urandom(), $urandom()};
            run_cmd(c, b, cnt, d, f, 1'b1, -1, -1, 1500);
            check("rand_done", 64'(done_cnt), 64'(1));
            check("rand_writes", 64'(wr_cnt), 64'(cnt));
            check("rand_mem", 64'(count_diff()), 64'(0));
        end

        // Full-RAM fill: every cell exactly once.
        run_cmd(1'b0, int'($urandom_range(0, N - 1)), N, 0, 64'hC0FF_EE00_C0FF_EE00, 1'b0, -1, -1, N + 100);
        bad = 0;
        for (int k = 0; k < N; k++) if (hits[k] != 1) bad++;
        check("full_hits", 64'(bad), 64'(0));
        check("full_done_cyc", 64'(done_rel), 64'(N + 2));
        check("full_mem", 64'(count_diff()), 64'(0));

        // Reset during MOVE_WAIT of the third scroll move.
        @(negedge clk_i);
        cmd_i = 1'b1; base_i = AW'(100); count_i = (AW+1)'(8); dist_i = AW'(2); fill_i = 64'h99;
        start_i = 1'b1; ram_gnt_i = 1'b1;
        start_edge = edge_cnt + 1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        check("rst_in_wait", 64'({ram_cs_o, ram_we_o, ram_adr_o}), 64'({1'b1, 1'b0, 14'd104}));
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_outs", 64'({busy_o, done_o, ram_cs_o, ram_we_o, ram_sel_o}) | 64'(ram_adr_o) | ram_dat_o, 64'(0));
        rst_ni = 1'b1;
        repeat (30) @(negedge clk_i);
        ref_mem[100] = ref_mem[102];
        ref_mem[101] = ref_mem[103];
        check("rst_writes", 64'(wr_cnt), 64'(2));
        check("rst_no_done", 64'(done_cnt), 64'(0));
        check("rst_mem", 64'(count_diff()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
